// File: rtl/dsp48a1_pkg.sv
// Shared definitions for the DSP48A1 post-adder/accumulator slice:
// datapath widths, OPMODE field positions and X/Z operand encodings.
package dsp48a1_pkg;

   // Datapath widths
   localparam int P_W = 48;   // P register / adder width
   localparam int M_W = 36;   // multiplier product width

   // OPMODE bit positions
   localparam int OPM_X_LO = 0;   // [1:0] X operand select
   localparam int OPM_Z_LO = 2;   // [3:2] Z operand select
   localparam int OPM_CIN  = 5;   // carry-in bit when taken from OPMODE
   localparam int OPM_SUB  = 7;   // 0 = add, 1 = subtract

   // X operand select encodings
   typedef enum logic [1:0] {
      X_ZERO = 2'b00,
      X_M    = 2'b01,
      X_P    = 2'b10,
      X_DAB  = 2'b11
   } x_sel_e;

   // Z operand select encodings
   typedef enum logic [1:0] {
      Z_ZERO = 2'b00,
      Z_PCIN = 2'b01,
      Z_P    = 2'b10,
      Z_C    = 2'b11
   } z_sel_e;

   // Decode the X select field out of a full OPMODE word
   function automatic x_sel_e get_x_sel(input logic [7:0] opm);
      return x_sel_e'(opm[OPM_X_LO +: 2]);
   endfunction

   // Decode the Z select field out of a full OPMODE word
   function automatic z_sel_e get_z_sel(input logic [7:0] opm);
      return z_sel_e'(opm[OPM_Z_LO +: 2]);
   endfunction

endpackage

// File: rtl/post_reg.sv
// Enable / synchronous-reset pipeline register with an optional bypass.
// q_reg is always the registered value (used for feedback paths);
// q is either q_reg or the raw input, chosen by USE_REG.
module post_reg #(
   parameter int W       = 1,
   parameter bit USE_REG = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q_reg,
   output logic [W-1:0] q
);

   // Storage: reset wins over the clock enable
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of block evaluation order.
      if (rst) begin
         q_reg <= '0;
      end else if (ce) begin
         q_reg <= d;
      end
   end

   // Output select: registered value or pass-through of the input
   generate
      if (USE_REG) begin : g_reg
         assign q = q_reg;
      end else begin : g_bypass
         assign q = d;
      end
   endgenerate

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/subtracter and accumulator stage.
// X and Z operands are picked by OPMODE, combined with a selectable carry-in,
// and held in the P register; P feedback always taps the internal register
// so that multiply-accumulate has no combinational loop even with PREG=0.
module dsp_post_adder_acc
   import dsp48a1_pkg::*;
#(
   parameter int PREG        = 1,
   parameter int CARRYINREG  = 1,
   parameter int CARRYOUTREG = 1,
   parameter     CARRYINSEL  = "OPMODE5"
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cep,
   input  logic           cecarryin,
   input  logic [7:0]     opmode,
   input  logic [M_W-1:0] m,
   input  logic [P_W-1:0] dab,
   input  logic [P_W-1:0] c,
   input  logic [P_W-1:0] pcin,
   input  logic           carryin,
   output logic [P_W-1:0] p,
   output logic [P_W-1:0] pcout,
   output logic           carryout,
   output logic           carryoutf
);

   logic           cin_raw;     // selected carry-in before the CYI stage
   logic           cin;         // carry-in actually seen by the adder
   logic           cyi_q_reg;   // CYI register value (only needed via cin)
   logic [P_W-1:0] p_reg;       // internal P register, feedback source
   logic [P_W-1:0] p_out;       // P register or adder result, per PREG
   logic           cyo_q_reg;   // CYO register value (only needed via carryout)
   logic           co_out;      // CYO register or adder carry, per CARRYOUTREG
   x_sel_e         x_sel;
   z_sel_e         z_sel;
   logic [P_W-1:0] x_opnd;
   logic [P_W-1:0] z_opnd;
   logic [P_W:0]   sum;         // 49-bit result, bit 48 is carry / borrow
   logic [P_W-1:0] result;
   logic           co;

   // Carry-in source is fixed at elaboration time
   generate
      if (CARRYINSEL == "OPMODE5") begin : g_cin_opmode
         assign cin_raw = opmode[OPM_CIN];
      end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
         assign cin_raw = carryin;
      end else begin : g_cin_bad
         $error("dsp_post_adder_acc: CARRYINSEL must be \"OPMODE5\" or \"CARRYIN\"");
         assign cin_raw = 1'b0;
      end
   endgenerate

   // CYI stage: aligns the carry-in with the upstream M register when used
   post_reg #(
      .W       (1),
      .USE_REG (CARRYINREG != 0)
   ) u_cyi (
      .clk   (clk),
      .rst   (rst),
      .ce    (cecarryin),
      .d     (cin_raw),
      .q_reg (cyi_q_reg),
      .q     (cin)
   );

   assign x_sel = get_x_sel(opmode);
   assign z_sel = get_z_sel(opmode);

   // Operand muxes and the 49-bit add/subtract
   always_comb begin
      // NOTE: every combinational output is given a default first, so no path
      // through the case statements can leave a value held (no latches).
      x_opnd = '0;
      z_opnd = '0;
      sum    = '0;

      case (x_sel)
         X_ZERO:  x_opnd = '0;
         X_M:     x_opnd = {{(P_W-M_W){1'b0}}, m};
         X_P:     x_opnd = p_reg;
         X_DAB:   x_opnd = dab;
         default: x_opnd = '0;
      endcase

      case (z_sel)
         Z_ZERO:  z_opnd = '0;
         Z_PCIN:  z_opnd = pcin;
         Z_P:     z_opnd = p_reg;
         Z_C:     z_opnd = c;
         default: z_opnd = '0;
      endcase

      // Subtract yields a borrow in bit 48 whenever X + cin exceeds Z
      if (opmode[OPM_SUB]) begin
         sum = {1'b0, z_opnd} - ({1'b0, x_opnd} + {{P_W{1'b0}}, cin});
      end else begin
         sum = {1'b0, z_opnd} + {1'b0, x_opnd} + {{P_W{1'b0}}, cin};
      end
   end

   assign result = sum[P_W-1:0];
   assign co     = sum[P_W];

   // P stage: always clocks on cep so feedback works for either PREG setting
   post_reg #(
      .W       (P_W),
      .USE_REG (PREG != 0)
   ) u_p (
      .clk   (clk),
      .rst   (rst),
      .ce    (cep),
      .d     (result),
      .q_reg (p_reg),
      .q     (p_out)
   );

   // CYO stage: tracks the P register's enable and reset
   post_reg #(
      .W       (1),
      .USE_REG (CARRYOUTREG != 0)
   ) u_cyo (
      .clk   (clk),
      .rst   (rst),
      .ce    (cep),
      .d     (co),
      .q_reg (cyo_q_reg),
      .q     (co_out)
   );

   assign p         = p_out;
   assign pcout     = p_out;
   assign carryout  = co_out;
   assign carryoutf = co_out;

   // Inputs and register taps that some configurations do not consume
   logic unused_bits;
   assign unused_bits = ^{opmode[6], opmode[4], carryin, cyi_q_reg, cyo_q_reg};

endmodule
